// File: rtl/muladd_dout_packer.sv
// Output side of the CPF-lane MAC/bias/ReLU stage: recreates the result strobe
// from the delayed end-of-packet pulse, packs PACK results LSB-first into one
// wide word, and queues the words in a first-word-fall-through FIFO.
module muladd_dout_packer #(
  parameter int DOUT_DW      = 8,
  parameter int DATA_CHANNEL = 1,
  parameter int PACK         = 4,
  parameter int LATENCY      = 6,
  parameter int FIFO_DEPTH   = 8,
  parameter int OUT_DW       = DOUT_DW * DATA_CHANNEL * PACK
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_din_eop,
  input  logic [DOUT_DW*DATA_CHANNEL-1:0] op_dout,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_DW-1:0]               out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
  output logic                            overflow
);

  localparam int W    = DOUT_DW * DATA_CHANNEL;
  localparam int IDXW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  logic [LATENCY-1:0] eop_dly;
  logic               cap;

  logic [IDXW-1:0]    pack_idx;
  logic [OUT_DW-1:0]  pack_reg;
  logic [OUT_DW-1:0]  pack_next;
  logic               push;

  logic [OUT_DW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               overflow_q;

  // Delay line: every eop travels LATENCY stages so back-to-back pulses all survive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eop_dly <= '0;
    end else begin
      eop_dly[0] <= op_din_eop;
      for (int i = 1; i < LATENCY; i++) begin
        eop_dly[i] <= eop_dly[i-1];
      end
    end
  end

  assign cap = eop_dly[LATENCY-1];

  // Word as it looks after this cycle's capture; also the value pushed on a flush
  always_comb begin
    pack_next = pack_reg;
    if (cap) begin
      pack_next[int'(pack_idx)*W +: W] = op_dout;
    end
  end

  // Push on the capture that fills the last slot, or on flush when anything is held
  assign push = (cap && (pack_idx == LAST_IDX)) ||
                (flush && (cap || (pack_idx != '0)));

  // Pack register and slot index; both restart whenever a word leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_idx <= '0;
      pack_reg <= '0;
    end else if (push) begin
      pack_idx <= '0;
      pack_reg <= '0;
    end else if (cap) begin
      pack_idx <= pack_idx + IDXW'(1);
      pack_reg <= pack_next;
    end
  end

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= pack_next;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (!wr_en && pop) begin
        count <= count - CW'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign fifo_cnt = count;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_muladd_dout_packer.sv
// Bench for muladd_dout_packer: a default instance checked every cycle against
// a queue-based reference model, plus two reconfigured instances exercising
// FIFO-full behaviour and dual-channel packing with a mid-operation reset.
module tb_muladd_dout_packer;

  localparam int M_PACK  = 4;
  localparam int M_LAT   = 6;
  localparam int M_DEPTH = 8;

  logic clk;
  logic rst0, rst1, rst2;

  logic        e0, f0, r0, v0, o0;
  logic [7:0]  d0;
  logic [31:0] od0;
  logic [3:0]  c0;

  logic        e1, f1, r1, v1, o1;
  logic [7:0]  d1;
  logic [7:0]  od1;
  logic [1:0]  c1;

  logic        e2, f2, r2, v2, o2;
  logic [15:0] d2;
  logic [31:0] od2;
  logic [3:0]  c2;

  int checks = 0;
  int errors = 0;

  // Reference model state for the default instance
  logic [7:0]  results[$];
  logic [31:0] fifo_q[$];
  bit          m_ovf = 1'b0;
  int          cyc = 0;
  bit          eop_hist[int];

  muladd_dout_packer dut0 (
    .clk(clk), .rst(rst0), .op_din_eop(e0), .op_dout(d0), .flush(f0),
    .out_valid(v0), .out_ready(r0), .out_data(od0), .fifo_cnt(c0), .overflow(o0)
  );

  muladd_dout_packer #(.PACK(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst1), .op_din_eop(e1), .op_dout(d1), .flush(f1),
    .out_valid(v1), .out_ready(r1), .out_data(od1), .fifo_cnt(c1), .overflow(o1)
  );

  muladd_dout_packer #(.DATA_CHANNEL(2), .PACK(2)) dut2 (
    .clk(clk), .rst(rst2), .op_din_eop(e2), .op_dout(d2), .flush(f2),
    .out_valid(v2), .out_ready(r2), .out_data(od2), .fifo_cnt(c2), .overflow(o2)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle of the spec's behaviour: pop, capture, then push or drop
  task automatic modelStep(input logic eop, input logic [7:0] dout, input logic fl, input logic rdy);
    bit cap;
    logic [31:0] word;
    cap = eop_hist.exists(cyc - M_LAT) && eop_hist[cyc - M_LAT];
    eop_hist[cyc] = eop;
    if (fifo_q.size() > 0 && rdy) void'(fifo_q.pop_front());
    if (cap) results.push_back(dout);
    if (results.size() == M_PACK || (fl && results.size() > 0)) begin
      word = 32'h0;
      foreach (results[k]) word = word | ({24'h0, results[k]} << (8 * k));
      results.delete();
      if (fifo_q.size() < M_DEPTH) fifo_q.push_back(word);
      else m_ovf = 1'b1;
    end
    cyc++;
  endtask

  task automatic compareModel();
    checkOutput("d0_valid", {31'h0, v0}, {31'h0, fifo_q.size() > 0});
    checkOutput("d0_data", od0, (fifo_q.size() > 0) ? fifo_q[0] : 32'h0);
    checkOutput("d0_cnt", {28'h0, c0}, 32'(fifo_q.size()));
    checkOutput("d0_ovf", {31'h0, o0}, {31'h0, m_ovf});
  endtask

  // Drive one cycle on the default instance, advance the model, compare
  task automatic applyStimulus(input logic eop, input logic [7:0] dout, input logic fl, input logic rdy);
    e0 = eop; d0 = dout; f0 = fl; r0 = rdy;
    modelStep(eop, dout, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  task automatic tick1(input logic eop, input logic [7:0] dout, input logic rdy);
    e1 = eop; d1 = dout; f1 = 1'b0; r1 = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick2(input logic eop, input logic [15:0] dout, input logic fl, input logic rdy);
    e2 = eop; d2 = dout; f2 = fl; r2 = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ready_pct[6];
    ready_pct[0] = 100; ready_pct[1] = 30; ready_pct[2] = 0;
    ready_pct[3] = 90;  ready_pct[4] = 10; ready_pct[5] = 100;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    e0 = 0; d0 = 0; f0 = 0; r0 = 0;
    e1 = 0; d1 = 0; f1 = 0; r1 = 0;
    e2 = 0; d2 = 0; f2 = 0; r2 = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'h0, v0}, 32'h0);
    checkOutput("rst_data", od0, 32'h0);
    checkOutput("rst_cnt", {28'h0, c0}, 32'h0);
    checkOutput("rst_ovf", {31'h0, o0}, 32'h0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Back-to-back packing: eops on 4 cycles, results six cycles later
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(i < 4, (i >= 6 && i <= 9) ? 8'(8'h11 * (i - 5)) : 8'h00, 1'b0, 1'b1);
      if (i == 8) checkOutput("b2b_early", {31'h0, v0}, 32'h0);
      if (i == 9) begin
        checkOutput("b2b_valid", {31'h0, v0}, 32'h1);
        checkOutput("b2b_word", od0, 32'h44332211);
      end
      if (i == 10) checkOutput("b2b_once", {31'h0, v0}, 32'h0);
    end

    // Partial word pushed by flush, then a flush with nothing held
    for (int i = 0; i <= 12; i++) begin
      applyStimulus(i < 2, (i == 6) ? 8'hA1 : ((i == 7) ? 8'hB2 : 8'h00), i == 11, 1'b1);
      if (i == 11) begin
        checkOutput("flush_valid", {31'h0, v0}, 32'h1);
        checkOutput("flush_word", od0, 32'h0000B2A1);
      end
      if (i == 12) checkOutput("flush_once", {31'h0, v0}, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, i == 1, 1'b1);
      checkOutput("flush_empty", {31'h0, v0}, 32'h0);
    end

    // Flush coinciding with the third capture, then a full word from slot 0
    for (int i = 0; i <= 9; i++) begin
      applyStimulus(i < 3, (i == 6) ? 8'hAA : ((i == 7) ? 8'hBB : ((i == 8) ? 8'hCC : 8'h00)), i == 8, 1'b1);
      if (i == 8) checkOutput("coinc_word", od0, 32'h00CCBBAA);
      if (i == 9) checkOutput("coinc_once", {31'h0, v0}, 32'h0);
    end
    for (int i = 0; i <= 9; i++) begin
      applyStimulus(i < 4, (i == 6) ? 8'hDD : ((i == 7) ? 8'hEE : ((i == 8) ? 8'hFF : ((i == 9) ? 8'h11 : 8'h00))), 1'b0, 1'b1);
      if (i == 9) checkOutput("after_coinc", od0, 32'h11FFEEDD);
    end

    // Randomised traffic with varying consumer back-pressure
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 100; i++) begin
        applyStimulus($urandom_range(0, 99) < 60, 8'($urandom),
                      $urandom_range(0, 99) < 6, $urandom_range(0, 99) < ready_pct[s]);
      end
    end
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'($urandom), i == 10, 1'b1);
    checkOutput("drained", {28'h0, c0}, 32'h0);

    // FIFO depth 2, one result per word: fill, overflow, then drain in order
    for (int i = 0; i <= 8; i++) tick1(i < 3, (i >= 6) ? 8'(i - 5) : 8'h00, 1'b0);
    checkOutput("full_cnt", {30'h0, c1}, 32'd2);
    checkOutput("full_ovf", {31'h0, o1}, 32'h1);
    checkOutput("full_head", {24'h0, od1}, 32'd1);
    tick1(1'b0, 8'h00, 1'b1);
    checkOutput("drain_2", {24'h0, od1}, 32'd2);
    checkOutput("drain_cnt", {30'h0, c1}, 32'd1);
    tick1(1'b0, 8'h00, 1'b1);
    checkOutput("drain_empty", {31'h0, v1}, 32'h0);

    // Push into a full FIFO while it is being read: no drop
    rst1 = 1'b1;
    tick1(1'b0, 8'h00, 1'b0);
    rst1 = 1'b0;
    checkOutput("rst1_ovf", {31'h0, o1}, 32'h0);
    for (int i = 0; i <= 8; i++) begin
      tick1(i < 3, (i >= 6) ? 8'(i - 1) : 8'h00, i == 8);
      if (i == 7) checkOutput("pp_fill", {30'h0, c1}, 32'd2);
    end
    checkOutput("pp_cnt", {30'h0, c1}, 32'd2);
    checkOutput("pp_ovf", {31'h0, o1}, 32'h0);
    checkOutput("pp_head", {24'h0, od1}, 32'd6);
    tick1(1'b0, 8'h00, 1'b1);
    checkOutput("pp_next", {24'h0, od1}, 32'd7);

    // Dual-channel packing
    for (int i = 0; i <= 8; i++) begin
      tick2(i < 2, (i == 6) ? 16'h0201 : ((i == 7) ? 16'h0403 : 16'h0000), 1'b0, 1'b1);
      if (i == 7) checkOutput("dual_word", od2, 32'h04030201);
      if (i == 8) checkOutput("dual_once", {31'h0, v2}, 32'h0);
    end

    // Reset with one eop in flight: nothing may come out afterwards
    tick2(1'b1, 16'h5555, 1'b0, 1'b1);
    tick2(1'b0, 16'h5555, 1'b0, 1'b1);
    rst2 = 1'b1;
    tick2(1'b0, 16'h5555, 1'b0, 1'b1);
    tick2(1'b0, 16'h5555, 1'b0, 1'b1);
    rst2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick2(1'b0, 16'($urandom) | 16'h0001, i == 10, 1'b1);
      checkOutput("mrst_valid", {31'h0, v2}, 32'h0);
      checkOutput("mrst_data", od2, 32'h0);
    end
    checkOutput("mrst_cnt", {28'h0, c2}, 32'h0);
    checkOutput("mrst_ovf", {31'h0, o2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
